// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main + skid entry, registered in_ready_o, flushable.
// Optional perf counters (bubble/stall) are enabled by PIPE_STAGE_ELASTIC_PERF_EN.
module pipe_stage_elastic #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_bubble_o,
  output logic [CNT_W-1:0]  perf_stall_o
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                accept, pop;

  assign accept = in_valid_i & in_ready_q;
  assign pop    = out_valid_q & out_ready_i;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d     = ONE;
          main_ctrl_d = in_ctrl_i;
          main_data_d = in_data_i;
        end
        ONE: begin
          if (accept && pop) begin
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end else if (accept) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
          end else if (pop) begin
            // Clearing main keeps the outputs at zero while empty.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_data_d = '0;
          end
        end
        FULL: if (pop) begin
          state_d     = ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = '0;
          skid_data_d = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_ctrl_o  = main_ctrl_q;
  assign out_data_o  = main_data_q;

`ifdef PIPE_STAGE_ELASTIC_PERF_EN
  logic [CNT_W-1:0] bubble_q, bubble_d, stall_q, stall_d;

  // Saturating counters; flush does not touch them.
  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (out_ready_i && !out_valid_q && (bubble_q != '1)) bubble_d = bubble_q + 1'b1;
    if (out_valid_q && !out_ready_i && (stall_q != '1))  stall_d  = stall_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
    end
  end

  assign perf_bubble_o = bubble_q;
  assign perf_stall_o  = stall_q;
`endif

endmodule
